// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode codes, the qualified flag bundle and the
// occupancy states of the result stage's two-entry buffer.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADDU = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUBU = 4'b0110;
  localparam logic [3:0] OP_NAND = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_SUB  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b1111;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_t;

endpackage

// File: rtl/alu_flag_qual.sv
// Maps an ALU opcode plus raw (possibly undefined) flags to fully defined
// {C,V,N,Z}; Z is always recomputed so z_in is never needed here.
module alu_flag_qual
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        alu_cntrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              c_in,
  input  logic              v_in,
  input  logic              n_in,
  output alu_flags_t        flags,
  output logic              illegal
);

  logic w_z;
  logic w_msb;

  // Opcode-group decode of qualified flags
  always_comb begin
    w_z     = (alu_out == {DATA_W{1'b0}});
    w_msb   = alu_out[DATA_W-1];
    flags   = 4'b0000;
    illegal = 1'b0;
    case (alu_cntrl)
      OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND: begin
        flags.c = 1'b0;
        flags.v = 1'b0;
        flags.n = w_msb;
        flags.z = w_z;
      end
      OP_SHL: begin
        flags.c = c_in;
        flags.v = 1'b0;
        flags.n = w_msb;
        flags.z = w_z;
      end
      OP_ADDU, OP_SUBU: begin
        flags.c = c_in;
        flags.v = v_in;
        flags.n = 1'b0;
        flags.z = w_z;
      end
      OP_ADD, OP_SUB: begin
        flags.c = c_in;
        flags.v = v_in;
        flags.n = n_in;
        flags.z = w_z;
      end
      default: begin
        flags   = 4'b0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_result_reg.sv
// Registered ALU output stage with valid/ready handshake, 2-entry skid buffer,
// sticky C/V and accept counter. Define ALU_RES_PARITY_EN to add result_par.
module alu_result_reg
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_cntrl,
  input  logic              c_in,
  input  logic              v_in,
  input  logic              n_in,
  input  logic              z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result_q,
  output logic [3:0]        flags_q,
  output logic [3:0]        op_q,
  output logic              illegal_q,
`ifdef ALU_RES_PARITY_EN
  output logic              result_par,
`endif
  output logic              sticky_c,
  output logic              sticky_v,
  input  logic              clear_sticky,
  output logic [CNT_W-1:0]  acc_count
);

  buf_state_t        r_state;
  buf_state_t        w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              w_accept;
  logic              w_deliver;
  logic              w_ld_new;
  logic              w_ld_skid;
  logic              w_ld_fwd;
  alu_flags_t        w_qflags;
  logic              w_illegal;
  logic [DATA_W-1:0] w_qresult;
  logic [DATA_W-1:0] r_out_res;
  alu_flags_t        r_out_flags;
  logic [3:0]        r_out_op;
  logic              r_out_ill;
  logic [DATA_W-1:0] r_skid_res;
  alu_flags_t        r_skid_flags;
  logic [3:0]        r_skid_op;
  logic              r_skid_ill;
  logic              r_sticky_c;
  logic              r_sticky_v;
  logic [CNT_W-1:0]  r_acc_cnt;
  logic              w_unused_z;

  // The stage never trusts the ALU's zero flag
  assign w_unused_z = z_in;

  assign w_accept  = in_valid & r_in_ready;
  assign w_deliver = r_out_valid & out_ready;

  alu_flag_qual #(.DATA_W(DATA_W)) u_flag_qual (
    .alu_cntrl (alu_cntrl),
    .alu_out   (alu_out),
    .c_in      (c_in),
    .v_in      (v_in),
    .n_in      (n_in),
    .flags     (w_qflags),
    .illegal   (w_illegal)
  );

  // Unimplemented opcodes capture a zero result
  always_comb begin
    if (w_illegal) begin
      w_qresult = {DATA_W{1'b0}};
    end else begin
      w_qresult = alu_out;
    end
  end

  // Buffer occupancy transitions and the data moves they imply
  always_comb begin
    w_state_nxt = r_state;
    w_ld_new    = 1'b0;
    w_ld_skid   = 1'b0;
    w_ld_fwd    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_ld_new    = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_accept && w_deliver) begin
          w_state_nxt = ST_ONE;
          w_ld_new    = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_TWO;
          w_ld_skid   = 1'b1;
        end else if (w_deliver) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_TWO: begin
        if (w_deliver) begin
          w_state_nxt = ST_ONE;
          w_ld_fwd    = 1'b1;
        end else begin
          w_state_nxt = ST_TWO;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State register, registered handshake outputs and entry storage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_res    <= {DATA_W{1'b0}};
      r_out_flags  <= 4'b0000;
      r_out_op     <= 4'b0000;
      r_out_ill    <= 1'b0;
      r_skid_res   <= {DATA_W{1'b0}};
      r_skid_flags <= 4'b0000;
      r_skid_op    <= 4'b0000;
      r_skid_ill   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_TWO);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      if (w_ld_new) begin
        r_out_res   <= w_qresult;
        r_out_flags <= w_qflags;
        r_out_op    <= alu_cntrl;
        r_out_ill   <= w_illegal;
      end else if (w_ld_fwd) begin
        r_out_res   <= r_skid_res;
        r_out_flags <= r_skid_flags;
        r_out_op    <= r_skid_op;
        r_out_ill   <= r_skid_ill;
      end
      if (w_ld_skid) begin
        r_skid_res   <= w_qresult;
        r_skid_flags <= w_qflags;
        r_skid_op    <= alu_cntrl;
        r_skid_ill   <= w_illegal;
      end
    end
  end

  // Sticky status: a clear drops history but never the flags accepted alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky_c <= 1'b0;
      r_sticky_v <= 1'b0;
    end else if (clear_sticky) begin
      r_sticky_c <= w_accept & w_qflags.c;
      r_sticky_v <= w_accept & w_qflags.v;
    end else begin
      r_sticky_c <= r_sticky_c | (w_accept & w_qflags.c);
      r_sticky_v <= r_sticky_v | (w_accept & w_qflags.v);
    end
  end

  // Free-running count of accepted results
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_acc_cnt <= r_acc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef ALU_RES_PARITY_EN
  logic r_out_par;
  logic r_skid_par;

  function automatic logic f_even_par(input logic [DATA_W-1:0] d);
    f_even_par = ^d;
  endfunction

  // Parity travels with its entry through both slots
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_par  <= 1'b0;
      r_skid_par <= 1'b0;
    end else begin
      if (w_ld_new) begin
        r_out_par <= f_even_par(w_qresult);
      end else if (w_ld_fwd) begin
        r_out_par <= r_skid_par;
      end
      if (w_ld_skid) begin
        r_skid_par <= f_even_par(w_qresult);
      end
    end
  end

  assign result_par = r_out_par;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result_q  = r_out_res;
  assign flags_q   = r_out_flags;
  assign op_q      = r_out_op;
  assign illegal_q = r_out_ill;
  assign sticky_c  = r_sticky_c;
  assign sticky_v  = r_sticky_v;
  assign acc_count = r_acc_cnt;

endmodule

// File: doc/alu_result_reg.md
Name: alu_result_reg

Overview:
- Registered output stage directly downstream of the 32-bit ALU. Captures ALU_Out, the C/V/N/Z flags and the 4-bit ALUCntrl code under a valid/ready handshake.
- Replaces don't-care flags with defined values per opcode and flags unimplemented opcodes.
- Holds sticky carry/overflow status for software and buffers through a 2-entry skid buffer so backpressure never drops a result.

Parameters:
- DATA_W, 32, result width (must match ALU).
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept; registered.
- alu_out  in  DATA_W  ALU_Out from ALU.
- alu_cntrl  in  4  ALUCntrl code that produced alu_out.
- c_in, v_in, n_in, z_in  in  1 each  ALU flags (may be X).
- out_valid  out  1  result_q valid.
- out_ready  in  1  consumer accepts.
- result_q  out  DATA_W  registered result.
- flags_q  out  4  qualified {C,V,N,Z}.
- op_q  out  4  registered ALUCntrl.
- illegal_q  out  1  result came from an unimplemented opcode.
- sticky_c, sticky_v  out  1 each  OR of qualified C/V over accepted results since last clear.
- clear_sticky  in  1  clears sticky bits.
- acc_count  out  CNT_W  number of accepted inputs, wraps.

Behaviour:
- Reset values: all outputs 0; in_ready=1 the cycle after reset deasserts; skid buffer empty.
- Accept: in_valid & in_ready at a rising edge.
- Deliver: out_valid & out_ready at a rising edge.
- Latency: 1 cycle. An input accepted at edge k appears on the outputs after edge k with out_valid=1.
- Flag qualification, applied at capture:
  - Logic ops 0000, 0001, 0011, 1100, 0111: C=0, V=0, N=alu_out[DATA_W-1], Z=(alu_out==0).
  - Shift 1101: C=c_in, V=0, N and Z as above.
  - Unsigned add/sub 0010, 0110: C=c_in, V=v_in, N=0, Z recomputed.
  - Signed add/sub 1010, 1110: all four flags from inputs, Z recomputed.
  - Any other code (0101, 1111, unused): result_q=0, flags=0, illegal_q=1. Still counts as accepted and still completes the handshake.
  - Z is always recomputed from alu_out; z_in is ignored. This guarantees no X on registered flags.
- States: EMPTY, ONE (output register full), TWO (output and skid full).
  - EMPTY: accept → ONE.
  - ONE, accept without deliver → TWO.
  - ONE, deliver without accept → EMPTY.
  - ONE, accept and deliver → ONE, new data.
  - TWO, deliver → ONE, skid moves to output.
  - TWO has no accept.
- in_ready = (state != TWO), registered. An accept in the same cycle as TWO is impossible.
- Ordering is strictly FIFO; no result is lost or duplicated.
- Sticky bits:
  - On accept: sticky_c |= qualified C and sticky_v |= qualified V, visible the cycle after accept.
  - clear_sticky takes priority only over the old value. Clear and accept in the same cycle → sticky = new accept's flags.
- acc_count increments on every accept and wraps from 2^CNT_W-1 to 0.
- Reset mid-transfer discards both buffered entries, sticky bits and count. The next cycle shows out_valid=0.
- While out_valid=1 and out_ready=0, result_q, flags_q, op_q and illegal_q hold stable.

Optional Feature:
- ALU_RES_PARITY_EN: adds output port result_par (1 bit), the even-parity bit of result_q (XOR of all bits). It is stored alongside each entry in both buffer slots, resets to 0, and follows the same handshake.
- Without the macro: no port and no parity logic; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_AND=0000, OP_OR=0001, OP_ADDU=0010, OP_XOR=0011, OP_SLTU=0101, OP_SUBU=0110, OP_NAND=0111, OP_ADD=1010, OP_NOR=1100, OP_SHL=1101, OP_SUB=1110, OP_SLT=1111;
  - a flag struct {c,v,n,z};
  - the state enum.
- One sub-module, alu_flag_qual: combinational opcode/flags → qualified flags plus illegal. It is shared later by the ALU testbench.

Test Plan:
- Single op: in_valid=1 with alu_out=0x0000_0000, op 0000, c_in=v_in=X → next cycle out_valid=1, result_q=0, flags_q=4'b0001, no X anywhere.
- Backpressure: out_ready=0, three back-to-back results 0x1, 0x2, 0x3 → 0x1 and 0x2 accepted, in_ready=0 before 0x3. Release out_ready → outputs 0x1, 0x2, 0x3 in order, acc_count=3.
- Signed overflow: op 1010, alu_out=0x8000_0000, c_in=0, v_in=1, n_in=1 → flags_q=4'b0110, sticky_v=1. clear_sticky with simultaneous op 0010 and c_in=1 → sticky_c=1, sticky_v=0.
- Illegal op: op 1111, alu_out=0xDEAD_BEEF → result_q=0, flags_q=0, illegal_q=1, acc_count increments.
- Reset mid-operation: state TWO, assert reset one cycle → out_valid=0, sticky bits 0, acc_count=0, in_ready=1 after release.
- Counter wrap with CNT_W=4: 17 accepts → acc_count=1. With ALU_RES_PARITY_EN and result 0x0000_0007 → result_par=1.
